// File: rtl/fetch_queue_pkg.sv
// Shared ibus types, fetch FSM state encoding and FIFO entry layout for the fetch front end.
// No logic; types and one PC helper only.
package fetch_queue_pkg;

    localparam int ADDR_W = 64;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [31:0]       u32;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        u32    instr;
    } fq_entry_t;

    function automatic addr_t word_align(input addr_t pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry fetch buffer with synchronous flush; flush outranks enqueue and dequeue.
// Latency: an entry written on an edge is visible at the head output after that edge.
// Backpressure: enqueue is dropped when full unless a dequeue frees a slot the same cycle.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        enq,
    input  fq_entry_t   enq_dat,
    input  logic        deq,
    output logic [AW:0] count,
    output logic        head_vld,
    output fq_entry_t   head_dat
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_enq;
    logic            do_deq;

    assign head_vld = (count != '0);
    assign do_deq   = deq && head_vld && !flush;
    assign do_enq   = enq && !flush && ((count != FULL_CNT) || do_deq);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) rd_ptr <= rd_ptr + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_dat;
    end

    // Storage is never reset, so the head is masked to zero while empty.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns fetch PC, issues one ibus request at a time, buffers into fq_fifo.
// Latency: addr_ok -> data_ok handled in WAIT -> entry at deq_* one edge later; deq_* are registered.
// Backpressure: no request issues while buffered plus outstanding fills DEPTH. Optional FETCH_PERF_EN adds counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output ibus_req_t        ireq,
    input  ibus_resp_t       iresp,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [XLEN-1:0]  deq_pc,
    output logic [31:0]      deq_instr,
`ifdef FETCH_PERF_EN
    output logic [63:0]      perf_fetched,
    output logic [63:0]      perf_flushed,
    output logic [63:0]      perf_stall,
`endif
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] ptag_pc;
    logic [AW:0]     count;
    logic            outstanding;
    logic            addr_fire;
    logic            enq;
    logic            deq;
    logic            space_now;
    logic            space_after;
    fq_entry_t       enq_dat;
    fq_entry_t       head_dat;

    assign outstanding = (state == WAIT);
    assign addr_fire   = (state == REQ) && iresp.addr_ok;
    assign enq         = (state == WAIT) && iresp.data_ok && !redirect_valid;
    assign deq         = deq_ready && !redirect_valid;
    assign space_now   = (int'(count) + int'(outstanding)) < DEPTH;
    // Room left once this cycle's response lands, crediting a same-cycle dequeue.
    assign space_after = (int'(count) + 1 - int'(deq_valid && deq_ready)) < DEPTH;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect_valid && space_now) state_nxt = REQ;
            end
            REQ: begin
                if (redirect_valid)     state_nxt = iresp.addr_ok ? DRAIN : IDLE;
                else if (iresp.addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (iresp.data_ok)      state_nxt = (redirect_valid || !space_after) ? IDLE : REQ;
                else if (redirect_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (iresp.data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ireq       = '0;
        ireq.valid = (state == REQ);
        ireq.addr  = (state == REQ) ? addr_t'(fetch_pc) : '0;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= PC_RESET;
            ptag_pc  <= '0;
        end else begin
            if (addr_fire) ptag_pc <= fetch_pc;
            if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (addr_fire) fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    assign enq_dat = '{pc: addr_t'(ptag_pc), instr: iresp.data};

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .enq      (enq),
        .enq_dat  (enq_dat),
        .deq      (deq),
        .count    (count),
        .head_vld (deq_valid),
        .head_dat (head_dat)
    );

    assign deq_pc    = XLEN'(head_dat.pc);
    assign deq_instr = head_dat.instr;

`ifdef FETCH_PERF_EN
    logic inflight;
    // A response still owed to us is lost once a redirect lands in WAIT or on an accepting REQ cycle.
    assign inflight = (state == WAIT) || addr_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq)            perf_fetched <= perf_fetched + 64'd1;
            if (redirect_valid) perf_flushed <= perf_flushed + 64'(count) + 64'(inflight);
            if ((state == REQ) && !iresp.addr_ok) perf_stall <= perf_stall + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic against a queue-level model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] PC_RST = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_instr;
    logic        busy;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched, perf_flushed, perf_stall;
`endif

    fetch_queue #(.DEPTH(DEPTH), .XLEN(64), .PC_RESET(PC_RST)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

    ent_t        mq[$];
    logic [63:0] acc_log[$];
    logic [63:0] exp_pc;
    bit          pending;
    bit          pend_discard;
    logic [63:0] pend_tag;
    logic [31:0] pend_data;
    int          pend_delay;
    int          max_delay;
    int          accepts;
    int          total = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive cache response, check outputs against the model, advance the model.
    task automatic cycle();
        bit acc;
        bit dok;
        iresp.data_ok = pending && (pend_delay == 0);
        iresp.data    = iresp.data_ok ? pend_data : 32'($urandom);
        chk("deq_valid", {63'd0, deq_valid}, {63'd0, mq.size() != 0});
        chk("deq_pc", deq_pc, (mq.size() != 0) ? mq[0].pc : 64'd0);
        chk("deq_instr", {32'd0, deq_instr}, (mq.size() != 0) ? {32'd0, mq[0].instr} : 64'd0);
        chk("busy", {63'd0, busy}, {63'd0, ireq.valid || pending});
        if (ireq.valid) chk("ireq_addr", ireq.addr, exp_pc);
        else            chk("ireq_addr_idle", ireq.addr, 64'd0);
        if (ireq.valid) chk("ireq_space", {63'd0, mq.size() < DEPTH}, 64'd1);

        acc = ireq.valid && iresp.addr_ok;
        dok = iresp.data_ok;
        if (pending && redirect_valid) pend_discard = 1;
        if (redirect_valid) mq.delete();
        else begin
            if (deq_valid && deq_ready && mq.size() != 0) void'(mq.pop_front());
            if (dok && !pend_discard) mq.push_back('{pend_tag, pend_data});
        end
        if (dok) pending = 0;
        else if (pending && pend_delay > 0) pend_delay--;
        if (acc) begin
            accepts++;
            acc_log.push_back(ireq.addr);
            pending      = 1;
            pend_discard = redirect_valid;
            pend_tag     = exp_pc;
            pend_data    = 32'($urandom);
            pend_delay   = $urandom_range(0, max_delay);
        end
        if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
        else if (acc)       exp_pc = exp_pc + 64'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        deq_ready      = 1'b0;
        iresp          = '0;
        @(posedge clk);
        @(negedge clk);
        pending = 0; pend_discard = 0; accepts = 0;
        mq.delete(); acc_log.delete();
        exp_pc = PC_RST;
        chk("rst_ireq_valid", {63'd0, ireq.valid}, 64'd0);
        chk("rst_ireq_addr", ireq.addr, 64'd0);
        chk("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("rst_deq_pc", deq_pc, 64'd0);
        chk("rst_deq_instr", {32'd0, deq_instr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 64'd0);
        chk("rst_perf_stall", perf_stall, 64'd0);
`endif
        reset = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int a0 = accepts;
        for (int i = 0; i < 30 && accepts == a0; i++) cycle();
        chk(tag, {63'd0, accepts != a0}, 64'd1);
    endtask

    initial begin
        int seen;
        logic [63:0] st0;
        max_delay = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0; iresp = '0;
        @(negedge clk);

        // Streaming with one-cycle cache and a ready consumer.
        do_reset();
        deq_ready = 1; iresp.addr_ok = 1;
        for (int i = 0; i < 12; i++) cycle();
        chk("seq_addr0", acc_log[0], 64'h8000_0000);
        chk("seq_addr1", acc_log[1], 64'h8000_0004);
        chk("seq_addr2", acc_log[2], 64'h8000_0008);

        // Stalled consumer: DEPTH requests then silence; one dequeue frees one slot.
        do_reset();
        iresp.addr_ok = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("full_accepts", 64'(accepts), 64'd4);
        chk("full_no_req", {63'd0, ireq.valid}, 64'd0);
        deq_ready = 1; cycle(); deq_ready = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("refill_accepts", 64'(accepts), 64'd5);
        chk("refill_addr", acc_log[acc_log.size()-1], 64'h8000_0010);

        // Redirect while waiting: response drained, fetch restarts at aligned target.
        do_reset();
        deq_ready = 1; iresp.addr_ok = 1;
        wait_accept("c_accept");
        pend_delay = 2; pend_data = 32'hDEAD_BEEF;
        iresp.addr_ok = 0; redirect_valid = 1; redirect_pc = 64'h8000_1003;
        cycle();
        redirect_valid = 0;
        chk("drain_busy", {63'd0, busy}, 64'd1);
        iresp.addr_ok = 1;
        wait_accept("c_restart");
        chk("drain_next_addr", acc_log[acc_log.size()-1], 64'h8000_1000);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (deq_valid && deq_instr == 32'hDEAD_BEEF) seen++;
            cycle();
        end
        chk("drain_dropped", 64'(seen), 64'd0);

        // Redirect coinciding with data_ok: no drain, data dropped.
        wait_accept("d_accept");
        pend_delay = 0;
        redirect_valid = 1; redirect_pc = 64'h8000_2000;
        cycle();
        redirect_valid = 0;
        chk("d_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("d_not_busy_drain", {63'd0, busy && !ireq.valid}, 64'd0);
        wait_accept("d_restart");
        chk("d_next_addr", acc_log[acc_log.size()-1], 64'h8000_2000);

        // addr_ok withheld for five REQ cycles: address must hold.
        iresp.addr_ok = 0;
        for (int i = 0; i < 30 && !ireq.valid; i++) cycle();
        chk("e_req_seen", {63'd0, ireq.valid}, 64'd1);
        st0 = ireq.addr;
`ifdef FETCH_PERF_EN
        begin
            logic [63:0] s0 = perf_stall;
            for (int i = 0; i < 5; i++) cycle();
            chk("perf_stall_delta", perf_stall - s0, 64'd5);
        end
`else
        for (int i = 0; i < 5; i++) cycle();
`endif
        chk("e_addr_stable", ireq.addr, st0);
        iresp.addr_ok = 1;

        // PC wrap at the top of the address space, then reset while waiting.
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        redirect_valid = 0;
        wait_accept("f_accept0");
        chk("wrap_addr0", acc_log[acc_log.size()-1], 64'hFFFF_FFFF_FFFF_FFFC);
        wait_accept("f_accept1");
        chk("wrap_addr1", acc_log[acc_log.size()-1], 64'h0);
        pend_delay = 2;
        do_reset();

        // Random traffic.
        max_delay = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            iresp.addr_ok  = ($urandom_range(0, 2) != 0);
            deq_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                         : {32'd0, $urandom};
            cycle();
        end
        redirect_valid = 0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the next-generation core, replacing the combinational PC-to-ibus path. Owns the fetch PC and issues sequential requests over the ibus handshake, with at most one request outstanding. Fetched instructions are buffered in a DEPTH-entry FIFO and drained by decode through a valid/ready port. Redirects from branch/jump resolution flush the FIFO and discard any in-flight response.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
XLEN, 64, PC/address width
PC_RESET, 64'h8000_0000, fetch PC after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset (0 = reset)
ireq  out  ibus_req_t  {valid, addr} to icache
iresp  in  ibus_resp_t  {addr_ok, data_ok, data[31:0]} from icache
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0
deq_valid  out  1  head entry valid
deq_ready  in  1  decode accepts head
deq_pc  out  XLEN  PC of head instruction
deq_instr  out  32  head instruction
busy  out  1  request outstanding or FSM not IDLE

Behaviour:
- Reset (reset==0 at a clk edge): fetch_pc=PC_RESET, FIFO empty, FSM=IDLE; ireq.valid=0, ireq.addr=0, deq_valid=0, deq_pc=0, deq_instr=0, busy=0. Reset mid-transaction abandons the request; the first data_ok after reset is ignored only if FSM is in DRAIN (it is not, so the bus side guarantees reset clears the cache too).
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE -> REQ when count + outstanding < DEPTH and no redirect. outstanding is 1 only in WAIT.
- REQ: ireq.valid=1 and ireq.addr=fetch_pc, held stable until addr_ok. On addr_ok: ptag_pc<=fetch_pc, fetch_pc+=4 with wrap modulo 2^XLEN, and FSM -> WAIT.
- WAIT: ireq.valid=0. On data_ok, write {ptag_pc, data} at the tail, then go to REQ if space remains, otherwise go to IDLE. addr_ok and data_ok in the same cycle are legal; the response is handled in WAIT, so there is a one-cycle minimum request-to-enqueue latency.
- DRAIN: entered when a redirect arrives in WAIT, or in REQ with addr_ok the same cycle. Waits for data_ok, discards the data, then goes to IDLE.
- Redirect, any state: FIFO cleared and fetch_pc=redirect_pc&~3 in the same edge. From REQ without addr_ok, the request is withdrawn and FSM -> IDLE. Redirect with data_ok in WAIT: data discarded, FSM -> IDLE, no DRAIN. A redirect outranks a same-cycle dequeue, and deq_valid=0 on the next cycle.
- Dequeue: a transfer occurs when deq_valid&&deq_ready. deq_* are registered FIFO head outputs with no combinational path from iresp. The head is zero when empty.
- Full FIFO: no new request issues. Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH and count is $clog2(DEPTH)+1 bits wide.
- Empty FIFO: deq_ready is ignored.

Optional Feature:
FETCH_PERF_EN: when defined, adds output ports perf_fetched[63:0] (instructions enqueued), perf_flushed[63:0] (entries plus in-flight responses discarded by redirect) and perf_stall[63:0] (cycles in REQ without addr_ok). All three reset to 0 and wrap on overflow. When undefined, the ports and counters are absent and there is no behavioural difference.

Decomposition:
- common package: ibus_req_t and ibus_resp_t (already present), plus new fetch_state_t enum {IDLE,REQ,WAIT,DRAIN} and typedef fq_entry_t {addr_t pc; u32 instr}.
- One sub-module, fq_fifo: a parametrised DEPTH-entry FIFO with flush, enq, deq and count outputs.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset with PC_RESET=0x8000_0000 and deq_ready=1; cache returns addr_ok and data_ok each next cycle -> ireq.addr sequence 0x80000000, 0x80000004, 0x80000008; deq_pc follows in order with matching instr.
- deq_ready=0 with DEPTH=4 -> exactly 4 requests issued, then ireq.valid stays 0. Raising deq_ready for 1 cycle -> one new request at 0x80000010.
- redirect to 0x80001003 while in WAIT -> FSM DRAIN; the next data_ok (instr 0xDEADBEEF) is not enqueued; the next ireq.addr is 0x80001000.
- redirect in the same cycle as data_ok -> no DRAIN, data dropped, deq_valid=0 the next cycle, request to redirect_pc issued.
- addr_ok held low for 5 cycles -> ireq.addr stable throughout. With FETCH_PERF_EN, perf_stall increases by 5.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC -> after addr_ok the next request goes to 0x0. Asserting reset (low) while in WAIT -> all outputs return to their reset values on the next edge.
